posit_acc_reducer: RTL and testbench

//   Upstream feeder and downstream consumer for the pipelined posit adder (positadd_4_es3).
//   It accepts a burst of posit operands on a valid/ready stream ending with a 'last' beat.
//   It repeatedly pairs operands and adder results, issues each pair to the adder, and

---
 rtl/posit_acc_reducer_if.sv | 26 ++
 rtl/posit_acc_reducer.sv | 109 ++++++++++
 tb/tb_posit_acc_reducer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_acc_reducer_if.sv
// rtl/posit_acc_reducer_if.sv - operand stream, adder port and sum output of the posit reducer
// slave is the reducer side; master is the feeder/adder/consumer side.
interface posit_acc_reducer_if #(
   parameter int N = 32
);
   logic [N-1:0] in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [N-1:0] add_in1;
   logic [N-1:0] add_in2;
   logic         add_start;
   logic [N-1:0] add_result;
   logic [N-1:0] sum_out;
   logic         sum_valid;

   modport master (
      output in_data, in_valid, in_last, add_result,
      input  in_ready, add_in1, add_in2, add_start, sum_out, sum_valid
   );

   modport slave (
      input  in_data, in_valid, in_last, add_result,
      output in_ready, add_in1, add_in2, add_start, sum_out, sum_valid
   );
endinterface

// File: rtl/posit_acc_reducer.sv
// rtl/posit_acc_reducer.sv - reduces a posit burst to one sum through an external pipelined adder
// Operands and returning sums share one FIFO pool; pairs are always taken oldest-first.
module posit_acc_reducer #(
   parameter int N       = 32,
   parameter int ES      = 3,
   parameter int LATENCY = 4,
   parameter int DEPTH   = 4
) (
   input logic                clk,
   input logic                rst_n,
   posit_acc_reducer_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);

   if (DEPTH < 3 || ES < 0 || LATENCY < 1) begin : g_param_check
      $error("posit_acc_reducer: DEPTH must be >= 3, ES >= 0, LATENCY >= 1");
   end

   typedef enum logic {ACCUM, DRAIN} state_t;

   state_t           state, state_nxt;
   logic [N-1:0]     pool     [DEPTH];
   logic [N-1:0]     pool_nxt [DEPTH];
   logic [CW-1:0]    count, count_nxt, fill;
   logic [LATENCY-1:0] pipe;
   logic             last_seen, last_seen_nxt;
   logic             issue, push_res, push_in, finish, in_ready;
   logic             start_q, sum_valid_q;
   logic [N-1:0]     in1_q, in2_q, sum_q;

   assign bus.in_ready  = in_ready;
   assign bus.add_in1   = in1_q;
   assign bus.add_in2   = in2_q;
   assign bus.add_start = start_q;
   assign bus.sum_out   = sum_q;
   assign bus.sum_valid = sum_valid_q;

   always_comb begin
      state_nxt     = state;
      last_seen_nxt = last_seen;
      in_ready      = (state == ACCUM);
      push_in       = bus.in_valid && in_ready;
      push_res      = pipe[LATENCY-1];
      issue         = (count >= CW'(2));
      finish        = (state == DRAIN) && last_seen && (count == CW'(1)) &&
                      !push_res && (pipe == '0) && !start_q;

      for (int i = 0; i < DEPTH; i++) pool_nxt[i] = pool[i];
      fill = count;
      if (issue) begin
         for (int i = 0; i < DEPTH - 2; i++) pool_nxt[i] = pool[i + 2];
         pool_nxt[DEPTH-2] = '0;
         pool_nxt[DEPTH-1] = '0;
         fill = count - CW'(2);
      end
      // Result lands ahead of the new beat so FIFO order follows arrival at the pool.
      if (push_res) begin
         for (int i = 0; i < DEPTH; i++)
            if (CW'(i) == fill) pool_nxt[i] = bus.add_result;
         fill = fill + CW'(1);
      end
      if (push_in) begin
         for (int i = 0; i < DEPTH; i++)
            if (CW'(i) == fill) pool_nxt[i] = bus.in_data;
         fill = fill + CW'(1);
         if (bus.in_last) begin
            last_seen_nxt = 1'b1;
            state_nxt     = DRAIN;
         end
      end
      count_nxt = fill;

      if (finish) begin
         for (int i = 0; i < DEPTH; i++) pool_nxt[i] = '0;
         count_nxt     = '0;
         last_seen_nxt = 1'b0;
         state_nxt     = ACCUM;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ACCUM;
         count       <= '0;
         pipe        <= '0;
         last_seen   <= 1'b0;
         start_q     <= 1'b0;
         in1_q       <= '0;
         in2_q       <= '0;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) pool[i] <= '0;
      end else begin
         assert (count_nxt <= CW'(3));
         state       <= state_nxt;
         count       <= count_nxt;
         last_seen   <= last_seen_nxt;
         pipe        <= (pipe << 1) | LATENCY'(start_q);
         start_q     <= issue;
         sum_valid_q <= finish;
         for (int i = 0; i < DEPTH; i++) pool[i] <= pool_nxt[i];
         if (issue) begin
            in1_q <= pool[0];
            in2_q <= pool[1];
         end
         if (finish) sum_q <= pool[0];
      end
   end
endmodule

// File: tb/tb_posit_acc_reducer.sv
// tb/tb_posit_acc_reducer.sv - randomized and directed bench for posit_acc_reducer
// A real-valued posit32/es3 adder stands in for the external adder; a queue model predicts every output.
module tb_posit_acc_reducer;
   localparam int N   = 32;
   localparam int LAT = 4;
   localparam logic [31:0] NAR = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   posit_acc_reducer_if #(.N(N)) bus ();
   posit_acc_reducer #(.N(N), .ES(3), .LATENCY(LAT), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- posit32 es3 arithmetic on reals ----------------
   function automatic real pow2(input int x);
      real r = 1.0;
      if (x >= 0) for (int i = 0; i < x; i++) r = r * 2.0;
      else        for (int i = 0; i < -x; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real pdec(input logic [31:0] p_in);
      logic [31:0] p = p_in;
      bit s = p[31];
      int m = 0, k, e = 0, idx;
      real f = 1.0, w = 0.5;
      if (p == 32'h0) return 0.0;
      if (s) p = -p;
      while (m < 31 && p[30-m] == p[30]) m++;
      k = p[30] ? m - 1 : -m;
      idx = 30 - m - 1;
      for (int j = 0; j < 3; j++) begin
         e = e * 2 + ((idx >= 0) ? int'(p[idx]) : 0);
         idx--;
      end
      while (idx >= 0) begin
         if (p[idx]) f = f + w;
         w = w / 2.0;
         idx--;
      end
      f = f * pow2(8 * k + e);
      return s ? -f : f;
   endfunction

   function automatic logic [31:0] penc(input real v);
      bit s = (v < 0.0);
      real a = s ? -v : v;
      int sc = 0, k, e, pos = 127;
      logic [127:0] bv = '0;
      logic [31:0] r;
      if (v == 0.0) return 32'h0;
      while (a >= 2.0) begin a = a / 2.0; sc++; end
      while (a < 1.0)  begin a = a * 2.0; sc--; end
      if (sc > 240)       r = 32'h7FFF_FFFF;
      else if (sc < -240) r = 32'h0000_0001;
      else begin
         k = (sc >= 0) ? sc / 8 : -((-sc + 7) / 8);
         e = sc - 8 * k;
         if (k >= 0) begin
            for (int j = 0; j < k + 1; j++) begin bv[pos] = 1'b1; pos--; end
            bv[pos] = 1'b0; pos--;
         end else begin
            for (int j = 0; j < -k; j++) begin bv[pos] = 1'b0; pos--; end
            bv[pos] = 1'b1; pos--;
         end
         for (int j = 2; j >= 0; j--) begin bv[pos] = e[j]; pos--; end
         a = a - 1.0;
         while (pos >= 0) begin
            a = a * 2.0;
            if (a >= 1.0) begin bv[pos] = 1'b1; a = a - 1.0; end
            pos--;
         end
         r = {1'b0, bv[127:97]} + {31'h0, bv[96]};
         if (r[31]) r = 32'h7FFF_FFFF;
         if (r == 32'h0) r = 32'h0000_0001;
      end
      return s ? -r : r;
   endfunction

   function automatic logic [31:0] padd(input logic [31:0] a, input logic [31:0] b);
      if (a == NAR || b == NAR) return NAR;
      return penc(pdec(a) + pdec(b));
   endfunction

   // ---------------- behavioural LAT-stage adder ----------------
   logic [31:0] st [LAT] = '{default: '0};
   always @(posedge clk) begin
      st[0] <= padd(bus.add_in1, bus.add_in2);
      for (int i = 1; i < LAT; i++) st[i] <= st[i-1];
   end
   assign bus.add_result = st[LAT-1];

   // ---------------- queue-level reference model ----------------
   typedef struct { int due; logic [31:0] val; } fl_t;
   logic [31:0] mpool [$];
   fl_t         infl [$];
   logic [31:0] msums [$];
   logic [31:0] dsums [$];
   bit          live = 1'b0, m_drain = 1'b0, m_start = 1'b0, m_sv = 1'b0;
   logic [31:0] m_in1, m_in2, m_sum;
   int          cyc = 0;
   int          start_cnt = 0;

   always @(posedge clk) begin
      bit issue, ret, fin;
      logic [31:0] a, b;
      fl_t t;
      if (!rst_n) begin
         live = 1'b1; m_drain = 1'b0; m_start = 1'b0; m_sv = 1'b0;
         m_in1 = '0; m_in2 = '0; m_sum = '0;
         mpool.delete(); infl.delete();
      end else if (live) begin
         issue = (mpool.size() >= 2);
         ret   = (infl.size() > 0) && (infl[0].due == cyc);
         fin   = m_drain && (mpool.size() == 1) && (infl.size() == 0);
         m_start = issue;
         if (issue) begin
            a = mpool.pop_front();
            b = mpool.pop_front();
            m_in1 = a; m_in2 = b;
            infl.push_back('{cyc + 1 + LAT, padd(a, b)});
         end
         if (ret) begin
            t = infl.pop_front();
            mpool.push_back(t.val);
         end
         if (!m_drain && bus.in_valid) begin
            mpool.push_back(bus.in_data);
            if (bus.in_last) m_drain = 1'b1;
         end
         m_sv = fin;
         if (fin) begin
            m_sum = mpool[0];
            msums.push_back(m_sum);
            mpool.delete();
            m_drain = 1'b0;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (live) begin
         check("in_ready", {31'h0, bus.in_ready}, {31'h0, !m_drain});
         check("add_start", {31'h0, bus.add_start}, {31'h0, m_start});
         if (m_start) begin
            check("add_in1", bus.add_in1, m_in1);
            check("add_in2", bus.add_in2, m_in2);
         end
         check("sum_valid", {31'h0, bus.sum_valid}, {31'h0, m_sv});
         if (m_sv) check("sum_out", bus.sum_out, m_sum);
         if (bus.sum_valid) dsums.push_back(bus.sum_out);
         if (bus.add_start) start_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   logic [31:0] beat_d [$];
   bit          beat_l [$];

   task automatic add_burst(input logic [31:0] v [$]);
      foreach (v[i]) begin
         beat_d.push_back(v[i]);
         beat_l.push_back(i == v.size() - 1);
      end
   endtask

   // Valid stays high on a stalled beat; gap is the percent chance of an idle cycle.
   task automatic drive_beats(input int gap);
      int i = 0, guard = 0;
      bit v;
      while (i < beat_d.size()) begin
         @(negedge clk);
         v = ($urandom_range(99) >= gap) || bus.in_valid;
         bus.in_valid = v;
         bus.in_data  = v ? beat_d[i] : $urandom;
         bus.in_last  = v && beat_l[i];
         if (v && bus.in_ready) begin i++; guard = 0; end
         guard++;
         if (guard > 400) begin
            check("drive_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      beat_d.delete();
      beat_l.delete();
   endtask

   task automatic wait_sums(input int target, input string name);
      int t = 0;
      while (dsums.size() < target && t < 2000) begin @(negedge clk); t++; end
      @(negedge clk);
      check(name, 32'(dsums.size() >= target), 32'd1);
   endtask

   task automatic expect_last(input string name, input logic [31:0] exp);
      if (dsums.size() > 0) check({name, "_dut"}, dsums[dsums.size()-1], exp);
      else                  check({name, "_dut"}, 32'hx, exp);
      if (msums.size() > 0) check({name, "_model"}, msums[msums.size()-1], exp);
      else                  check({name, "_model"}, 32'hx, exp);
   endtask

   initial begin
      int n0, s0, len;
      logic [31:0] v [$];
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
      repeat (3) @(negedge clk);
      check("rst_add_start", {31'h0, bus.add_start}, 32'd0);
      check("rst_add_in1", bus.add_in1, 32'd0);
      check("rst_add_in2", bus.add_in2, 32'd0);
      check("rst_sum_valid", {31'h0, bus.sum_valid}, 32'd0);
      check("rst_sum_out", bus.sum_out, 32'd0);
      check("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
      rst_n = 1'b1;

      // single beat: returns operand two edges after acceptance, adder unused
      s0 = start_cnt;
      v = '{32'h4000_0000}; add_burst(v);
      drive_beats(0);
      check("t1_no_early_sum", {31'h0, bus.sum_valid}, 32'd0);
      @(negedge clk);
      check("t1_sum_valid", {31'h0, bus.sum_valid}, 32'd1);
      check("t1_sum_out", bus.sum_out, 32'h4000_0000);
      @(negedge clk);
      check("t1_starts", 32'(start_cnt - s0), 32'd0);

      n0 = dsums.size(); s0 = start_cnt;
      v = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000}; add_burst(v);
      drive_beats(0);
      wait_sums(n0 + 1, "t2_done");
      expect_last("t2_sum", 32'h4800_0000);
      check("t2_starts", 32'(start_cnt - s0), 32'd3);

      n0 = dsums.size();
      v = '{32'h4000_0000, NAR, 32'h4400_0000}; add_burst(v);
      drive_beats(0);
      wait_sums(n0 + 1, "t3_done");
      expect_last("t3_nar", NAR);

      // reset while pairs are in flight drops the burst
      n0 = dsums.size();
      v = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000}; add_burst(v);
      drive_beats(0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("t4_no_sum", 32'(dsums.size()), 32'(n0));
      v = '{32'h4400_0000, 32'h4400_0000}; add_burst(v);
      drive_beats(0);
      wait_sums(n0 + 1, "t4_done");
      expect_last("t4_sum", 32'h4800_0000);

      // back-to-back bursts with valid held high through DRAIN
      n0 = dsums.size();
      v = '{32'h4400_0000, 32'h4400_0000, 32'h4400_0000}; add_burst(v);
      v = '{32'h4000_0000, 32'h4000_0000}; add_burst(v);
      drive_beats(0);
      wait_sums(n0 + 2, "t5_done");
      check("t5_sum_a", dsums[n0], 32'h4A00_0000);
      check("t5_sum_b", dsums[n0+1], 32'h4400_0000);
      check("t5_model_a", msums[n0], 32'h4A00_0000);

      // random bursts against the model
      for (int b = 0; b < 300; b++) begin
         n0 = dsums.size();
         len = $urandom_range(1, 64);
         v.delete();
         for (int i = 0; i < len; i++) begin
            case ($urandom_range(31))
               0:       v.push_back(NAR);
               1, 2:    v.push_back(32'h0);
               default: v.push_back($urandom);
            endcase
         end
         add_burst(v);
         drive_beats($urandom_range(0, 40));
         wait_sums(n0 + 1, "rand_done");
      end
      repeat (5) @(negedge clk);
      check("sum_count", 32'(dsums.size()), 32'(msums.size()));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
